// File: rtl/game_stats_counter_if.sv
// Bundles the game control inputs and the display-facing outputs of game_stats_counter.
// With GAME_PAUSE_EN defined the bundle also carries the pause level.
interface game_stats_counter_if;
    logic        start;
    logic        hit;
`ifdef GAME_PAUSE_EN
    logic        pause;
`endif
    logic [31:0] timer;
    logic [31:0] currentScore;
    logic [31:0] highScore;
    logic        running;
    logic        gameOver;

`ifdef GAME_PAUSE_EN
    modport master (output start, hit, pause,
                    input  timer, currentScore, highScore, running, gameOver);
    modport slave  (input  start, hit, pause,
                    output timer, currentScore, highScore, running, gameOver);
`else
    modport master (output start, hit,
                    input  timer, currentScore, highScore, running, gameOver);
    modport slave  (input  start, hit,
                    output timer, currentScore, highScore, running, gameOver);
`endif
endinterface

// File: rtl/game_stats_counter.sv
// Game countdown timer, hit score and best-score keeper feeding a two-digit display.
// Optional macro GAME_PAUSE_EN adds a pause input that freezes the running game.
module game_stats_counter #(
    parameter int CLK_HZ       = 50000000,
    parameter int GAME_SECONDS = 60,
    parameter int SCORE_MAX    = 99
) (
    input  logic                  CLK50MHZ,
    input  logic                  RESETN,
    game_stats_counter_if.slave   bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [6:0]    GAME_SEC   = 7'(GAME_SECONDS);
    localparam logic [6:0]    SCORE_LIM  = 7'(SCORE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [6:0]      timer_q, timer_d;
    logic [6:0]      score_q, score_d;
    logic [6:0]      high_q, high_d;
    logic            start_q, start_d;
    logic            hit_q, hit_d;
    logic            running_q, running_d;
    logic            gameover_q, gameover_d;

    logic            start_re_s;
    logic            hit_re_s;
    logic            pause_s;
    logic            tick_s;
    logic [6:0]      score_inc_s;

`ifdef GAME_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    assign start_re_s = bus.start & ~start_q;
    assign hit_re_s   = bus.hit & ~hit_q;
    assign tick_s     = (state_q == ST_RUN) && !pause_s && (presc_q == PRESC_LAST);

    // Next-state, counter and score computation
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        timer_d     = timer_q;
        score_d     = score_q;
        high_d      = high_q;
        start_d     = bus.start;
        hit_d       = bus.hit;

        if (hit_re_s && (score_q < SCORE_LIM)) begin
            score_inc_s = score_q + 7'd1;
        end else begin
            score_inc_s = score_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                presc_d = PRESC_ZERO;
                if (start_re_s) begin
                    state_d = ST_RUN;
                    timer_d = GAME_SEC;
                    score_d = 7'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                // Pause freezes the whole game, including the partial second.
                if (pause_s) begin
                    presc_d = presc_q;
                end else begin
                    score_d = score_inc_s;
                    if (tick_s) begin
                        presc_d = PRESC_ZERO;
                        if (timer_q > 7'd1) begin
                            timer_d = timer_q - 7'd1;
                        end else begin
                            timer_d = 7'd0;
                            state_d = ST_DONE;
                            high_d  = (score_inc_s > high_q) ? score_inc_s : high_q;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = PRESC_ZERO;
            end
        endcase

        running_d  = (state_d == ST_RUN);
        gameover_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge CLK50MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            presc_q    <= PRESC_ZERO;
            timer_q    <= GAME_SEC;
            score_q    <= 7'd0;
            high_q     <= 7'd0;
            start_q    <= 1'b0;
            hit_q      <= 1'b0;
            running_q  <= 1'b0;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            timer_q    <= timer_d;
            score_q    <= score_d;
            high_q     <= high_d;
            start_q    <= start_d;
            hit_q      <= hit_d;
            running_q  <= running_d;
            gameover_q <= gameover_d;
        end
    end

    assign bus.timer        = {25'd0, timer_q};
    assign bus.currentScore = {25'd0, score_q};
    assign bus.highScore    = {25'd0, high_q};
    assign bus.running      = running_q;
    assign bus.gameOver     = gameover_q;
endmodule
